// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : shared FSM states, parity modes and counter-width helper      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Bits needed for a counter running 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_buffered_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_buffered_if : valid/ready word handshake into the UART transmitter|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface uart_tx_buffered_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_BITS-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_fifo : synchronous FIFO with full/empty/level, async reset        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_data,
  input  logic                             pop,
  output logic [WIDTH-1:0]                 pop_data,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH+1)-1:0]       level
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_lvl_w = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_lvl_w-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  assign full     = (r_count == c_lvl_w'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;
  assign pop_data = r_mem[r_rd_ptr];
  assign level    = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_buffered : FIFO-buffered UART transmitter, optional parity via    |
// | UART_TX_PARITY_EN.  Rev 1.0                                               |
// +--------------------------------------------------------------------------+
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  uart_tx_buffered_if.slave                  s,
  input  logic [1:0]                         parity_mode,
  output logic                               tx,
  output logic                               tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);
  localparam int c_clk_w = cnt_width(CLKS_PER_BIT);
  localparam int c_bit_w = cnt_width(DATA_BITS);

  uart_state_e          r_state;
  uart_state_e          w_next;
  logic [c_clk_w-1:0]   r_clk_cnt;
  logic [c_bit_w-1:0]   r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_fifo_data;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_done;
  logic                 w_last_data;
  logic                 w_last_stop;
  logic                 w_tx;
  logic                 w_busy;

  assign s.s_ready   = !w_full;
  assign w_push      = s.s_valid && !w_full;
  assign w_bit_done  = (r_clk_cnt == c_clk_w'(CLKS_PER_BIT - 1));
  assign w_last_data = (r_bit_cnt == c_bit_w'(DATA_BITS - 1));
  assign w_last_stop = (r_bit_cnt == c_bit_w'(STOP_BITS - 1));

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (s.s_data),
    .pop       (w_pop),
    .pop_data  (w_fifo_data),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level)
  );

`ifdef UART_TX_PARITY_EN
  logic [1:0] r_par_mode;
  logic       r_par_bit;
  logic       w_par_en;

  assign w_par_en = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);

  // Mode and parity are captured at pop so mid-frame changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_mode <= PAR_NONE;
      r_par_bit  <= 1'b0;
    end else if (w_pop) begin
      r_par_mode <= parity_mode;
      r_par_bit  <= (^w_fifo_data) ^ (parity_mode == PAR_ODD);
    end
  end
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (!w_empty) w_next = START;
      START:  if (w_bit_done) w_next = DATA;
      DATA: begin
        if (w_bit_done && w_last_data) begin
`ifdef UART_TX_PARITY_EN
          w_next = w_par_en ? PARITY : STOP;
`else
          w_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_bit_done) w_next = STOP;
`endif
      STOP:   if (w_bit_done && w_last_stop) w_next = w_empty ? IDLE : START;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_pop  = 1'b0;
    w_tx   = 1'b1;
    w_busy = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        w_pop  = !w_empty;
      end
      START:  w_tx  = 1'b0;
      DATA:   w_tx  = r_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: w_tx  = r_par_bit;
`endif
      STOP:   w_pop = w_bit_done && w_last_stop && !w_empty;
      default: w_busy = 1'b0;
    endcase
  end

  // Line outputs are registered, so they trail the state by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      tx      <= w_tx;
      tx_busy <= w_busy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state == IDLE || w_bit_done) r_clk_cnt <= '0;
      else                               r_clk_cnt <= r_clk_cnt + 1'b1;

      if (r_state != w_next) r_bit_cnt <= '0;
      else if (w_bit_done)   r_bit_cnt <= r_bit_cnt + 1'b1;

      if (w_pop)                              r_shift <= w_fifo_data;
      else if (r_state == DATA && w_bit_done) r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_buffered : scoreboard bench for uart_tx_buffered               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_uart_tx_buffered;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] pm8, pm7;
  logic       tx8, busy8, tx7, busy7;
  logic [2:0] lvl8, lvl7;

  always #5 clk = ~clk;

  uart_tx_buffered_if #(.DATA_BITS(8)) bus8 ();
  uart_tx_buffered_if #(.DATA_BITS(7)) bus7 ();

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus8), .parity_mode(pm8),
    .tx(tx8), .tx_busy(busy8), .fifo_level(lvl8));

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) dut7 (
    .clk(clk), .rst_n(rst_n), .s(bus7), .parity_mode(pm7),
    .tx(tx7), .tx_busy(busy7), .fifo_level(lvl7));

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    logic [8:0]  data;
  } frame_t;

  frame_t sb_q[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     run = 0;
  int     last_run = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t make_frame(input logic [8:0] d, input int w, input logic [1:0] pm,
                                        input int stops);
    frame_t f;
    int     n = 0;
    logic   p = 1'b0;
    logic   use_par = (pm == 2'b01) || (pm == 2'b10);
`ifndef UART_TX_PARITY_EN
    use_par = 1'b0;
`endif
    f.bits = '1;
    f.data = d;
    f.bits[n] = 1'b0; n++;
    for (int i = 0; i < w; i++) begin
      f.bits[n] = d[i]; n++;
      p = p ^ d[i];
    end
    if (use_par) begin
      f.bits[n] = (pm == 2'b10) ? ~p : p; n++;
    end
    n = n + stops;
    f.nbits = n;
    return f;
  endfunction

  // Samples one frame starting at the current negedge (first start-bit cycle).
  task automatic watch_frame(input bit sel, input frame_t f, input string tag);
    int             busy_cnt = 0;
    logic [CPB-1:0] samp;
    logic           b;
    for (int k = 0; k < f.nbits; k++) begin
      for (int c = 0; c < CPB; c++) begin
        if (!(k == 0 && c == 0)) @(negedge clk);
        if (!rst_n) return;
        samp[c] = sel ? tx7 : tx8;
        if (sel ? busy7 : busy8) busy_cnt++;
      end
      b = (samp == '1) ? 1'b1 : (samp == '0) ? 1'b0 : 1'bx;
      chk($sformatf("%s bit%0d", tag, k), {31'b0, b}, {31'b0, f.bits[k]});
    end
    chk({tag, " busy cycles"}, busy_cnt, f.nbits * CPB);
  endtask

  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      if (rst_n && tx8 === 1'b0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected frame", 32'd1, 32'd0);
          while (rst_n && tx8 === 1'b0) @(negedge clk);
        end else begin
          f = sb_q.pop_front();
          watch_frame(1'b0, f, $sformatf("frame %02h", f.data));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (busy8) run <= run + 1;
    else begin
      if (run != 0) last_run <= run;
      run <= 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push8(input logic [7:0] d);
    chk("s_ready before push", bus8.s_ready, 1);
    bus8.s_valid = 1'b1;
    bus8.s_data  = d;
    sb_q.push_back(make_frame({1'b0, d}, 8, pm8, 1));
    @(negedge clk);
    bus8.s_valid = 1'b0;
  endtask

  task automatic wait_idle8(input string tag, input int budget);
    int n = 0;
    while ((busy8 !== 1'b0 || lvl8 !== 3'd0 || sb_q.size() != 0 || tx8 !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " idle within budget"}, n < budget, 1);
    @(negedge clk);
  endtask

  initial begin
    int         acc;
    int         n;
    logic [7:0] d;
    bit         took;
    int         plen;
`ifdef UART_TX_PARITY_EN
    plen = 44;
`else
    plen = 40;
`endif
    pm8 = 2'b00; pm7 = 2'b00;
    bus8.s_valid = 1'b0; bus8.s_data = '0;
    bus7.s_valid = 1'b0; bus7.s_data = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("reset tx", tx8, 1);
    chk("reset busy", busy8, 0);
    chk("reset level", lvl8, 0);
    chk("reset ready", bus8.s_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset tx", tx8, 1);

    // Basic frame with latency checks
    bus8.s_valid = 1'b1; bus8.s_data = 8'hA5;
    sb_q.push_back(make_frame(9'h0A5, 8, pm8, 1));
    @(negedge clk);
    bus8.s_valid = 1'b0;
    chk("E level", lvl8, 1);
    chk("E tx", tx8, 1);
    @(negedge clk);
    chk("E+1 level", lvl8, 0);
    chk("E+1 tx", tx8, 1);
    chk("E+1 busy", busy8, 0);
    @(negedge clk);
    chk("E+2 tx", tx8, 0);
    chk("E+2 busy", busy8, 1);
    wait_idle8("basic", 200);
    chk("basic busy run", last_run, 40);

    // Parity: even, mode changed mid-frame, odd, then 11 (none)
    pm8 = 2'b01;
    push8(8'hA5);
    repeat (10) @(negedge clk);
    pm8 = 2'b10;
    wait_idle8("even", 200);
    chk("even busy run", last_run, plen);
    push8(8'hA5);
    wait_idle8("odd", 200);
    chk("odd busy run", last_run, plen);
    pm8 = 2'b11;
    push8(8'h3C);
    wait_idle8("mode11", 200);
    chk("mode11 busy run", last_run, 40);
    pm8 = 2'b00;

    // Back-to-back frames
    push8(8'h00);
    push8(8'hFF);
    push8(8'h55);
    wait_idle8("b2b", 400);
    chk("b2b busy run", last_run, 120);

    // Full FIFO while a frame is in progress
    push8(8'h3C);
    repeat (2) @(negedge clk);
    chk("full pre busy", busy8, 1);
    chk("full pre level", lvl8, 0);
    acc = 0; d = 8'h11;
    bus8.s_valid = 1'b1; bus8.s_data = d;
    for (int c = 0; c < 6; c++) begin
      took = bus8.s_ready;
      if (took) begin
        sb_q.push_back(make_frame({1'b0, d}, 8, pm8, 1));
        acc++;
      end
      @(negedge clk);
      if (took) begin
        d = d + 8'h11;
        bus8.s_data = d;
      end
    end
    bus8.s_valid = 1'b0;
    chk("full accepted", acc, 4);
    chk("full level", lvl8, 4);
    chk("full ready", bus8.s_ready, 0);
    wait_idle8("full", 400);
    chk("full busy run", last_run, 200);

    // 7-bit data, two stop bits, odd parity
    pm7 = 2'b10;
    bus7.s_valid = 1'b1; bus7.s_data = 7'h7F;
    @(negedge clk);
    bus7.s_valid = 1'b0;
    n = 0;
    while (tx7 !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("w7 start seen", n < 10, 1);
    watch_frame(1'b1, make_frame(9'h07F, 7, pm7, 2), "w7");
    @(negedge clk);
    chk("w7 after tx", tx7, 1);
    chk("w7 after busy", busy7, 0);

    // Reset during the 3rd data bit
    push8(8'hA5);
    push8(8'h5A);
    chk("push+pop level", lvl8, 1);
    push8(8'h33);
    chk("mid level", lvl8, 2);
    chk("mid start tx", tx8, 0);
    repeat (12) @(negedge clk);
    chk("mid busy", busy8, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort tx", tx8, 1);
    chk("abort busy", busy8, 0);
    chk("abort level", lvl8, 0);
    chk("abort ready", bus8.s_ready, 1);
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("recover tx", tx8, 1);
    chk("recover busy", busy8, 0);
    push8(8'hC3);
    wait_idle8("recover", 200);
    chk("recover busy run", last_run, 40);

    chk("scoreboard drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised UART transmitter with a built-in transmit FIFO and a valid/ready input handshake. It is the successor to the single-byte pulse-started transmitter. It adds configurable data width, stop-bit count, runtime-selectable parity, and gap-free back-to-back frames. It sits between on-chip logic and the serial pin.

## Interface
Parameters:
- CLKS_PER_BIT, 10: system clocks per serial bit; legal values ≥ 2.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 4: transmit FIFO entries; power of two, ≥ 2.

Ports (reset: rst_n, asynchronous, active-low; clock: clk):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  FIFO can accept a word.
- s_data  in  DATA_BITS  word to transmit.
- parity_mode  in  2  parity select: 00 none, 01 even, 10 odd, 11 none.
- tx  out  1  serial output; idles high.
- tx_busy  out  1  a frame is on the line.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  number of words queued.

## Operation
- Push: a word is written into the FIFO on a clk edge where s_valid && s_ready.
- s_ready = (fifo_level != FIFO_DEPTH). It is decoded from registered state only; no combinational path from s_valid.
- Frame format: start bit (0), then data bits LSB first, then the parity bit if enabled, then STOP_BITS stop bits (1).
- FSM states:
  - IDLE: tx = 1. If the FIFO is not empty: pop the head, load the shift register, latch parity_mode, go to START.
  - START → DATA.
  - DATA: after DATA_BITS bits, go to PARITY if the latched mode is even or odd, otherwise go to STOP.
  - PARITY → STOP.
  - STOP: after STOP_BITS bits, if the FIFO is not empty, pop and go directly to START (no idle cycle); otherwise go to IDLE.
- Parity bit value:
  - Even: XOR of the data bits.
  - Odd: inverted XOR of the data bits.
  - parity_mode changes during a frame have no effect on that frame.
- tx and tx_busy are registered.
  - tx_busy is high from the first start-bit cycle through the last stop-bit cycle.
  - tx_busy stays high continuously across back-to-back frames.
- FIFO boundary conditions:
  - Push and pop on the same edge leave fifo_level unchanged.
  - Push when full cannot occur, because s_ready is low.
  - Pop only happens when the FIFO is not empty.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset values:
  - tx = 1, tx_busy = 0, fifo_level = 0, s_ready = 1.
  - FSM = IDLE, and all counters are 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronously) and discards all FIFO contents.

## Timing
- Each bit on tx lasts exactly CLKS_PER_BIT cycles.
- Frame length = CLKS_PER_BIT × (1 + DATA_BITS + P + STOP_BITS), where P = 1 with parity and 0 without.
- Latency: a word accepted into an empty FIFO while in IDLE at edge E is popped at edge E+1; tx goes low after edge E+2.
- fifo_level updates on the edge after a push or pop.
- Back-to-back: the next start bit directly follows the last stop-bit cycle, with zero idle cycles.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state and parity generation are built, and parity_mode is honoured.
- Undefined: the PARITY state is not generated and parity_mode is ignored. Every frame is 1 + DATA_BITS + STOP_BITS bits. The port is kept so the interface stays stable.

## Structure
- Shared package (uart_pkg):
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Parity-mode localparams (PAR_NONE, PAR_EVEN, PAR_ODD).
  - The bit-count width helper.
- One sub-module: uart_tx_fifo, a synchronous FIFO with full/empty/level outputs, parametrised by width and depth.
- Top level: FSM, bit and clock counters, and the shift register.

## Test plan
All scenarios use CLKS_PER_BIT = 4 unless stated otherwise.
- Basic frame: DATA_BITS = 8, no parity; push 0xA5 → tx levels 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; tx_busy high for exactly 40 cycles.
- Parity: push 0xA5 with parity_mode = 01 → parity bit 0; with 10 → parity bit 1; frame is 44 cycles. Compile without UART_TX_PARITY_EN → both frames are 40 cycles.
- Back-to-back: push 0x00, 0xFF, 0x55 on 3 consecutive cycles → all accepted, three contiguous frames, tx_busy high for 120 cycles with no idle gap.
- Full FIFO: with a frame in progress, hold s_valid high for 6 cycles → 4 words accepted, s_ready low after the 4th, fifo_level = 4, and no words lost or duplicated.
- Odd width: DATA_BITS = 7, STOP_BITS = 2, odd parity, push 0x7F → parity bit 0, two stop bits, frame is 44 cycles.
- Reset mid-frame: assert rst_n low during the 3rd data bit → tx = 1, tx_busy = 0, fifo_level = 0, s_ready = 1, all without waiting for a clock edge.
